// File: rtl/taylor_seq_ctrl_pkg.sv
// rtl/taylor_seq_ctrl_pkg.sv - shared constants, state type and helpers for the Taylor sequencer
// Purpose: function encodings, 1/k! coefficient table in Q1.15, Q1.15 constants,
//          FSM state type, and small helpers for term selection, sign and saturation.
// Ports:   none (package).
package taylor_seq_ctrl_pkg;

  localparam logic [1:0] FN_EXP = 2'd0;
  localparam logic [1:0] FN_SIN = 2'd1;
  localparam logic [1:0] FN_COS = 2'd2;
  localparam logic [1:0] FN_ILL = 2'd3;

  localparam logic [15:0] C1 = 16'h7FFF;
  localparam logic [15:0] C2 = 16'h4000;
  localparam logic [15:0] C3 = 16'h1555;
  localparam logic [15:0] C4 = 16'h0555;
  localparam logic [15:0] C5 = 16'h0111;
  localparam logic [15:0] C6 = 16'h002E;
  localparam logic [15:0] C7 = 16'h0007;
  localparam logic [15:0] C8 = 16'h0001;

  localparam logic [15:0] ONE_Q15 = 16'h8000;
  localparam logic [15:0] SAT_POS = 16'h7FFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_POW_START,
    S_POW_WAIT,
    S_COEF_START,
    S_COEF_WAIT,
    S_ACC,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic logic [15:0] coef(input logic [3:0] k);
    case (k)
      4'd1:    return C1;
      4'd2:    return C2;
      4'd3:    return C3;
      4'd4:    return C4;
      4'd5:    return C5;
      4'd6:    return C6;
      4'd7:    return C7;
      4'd8:    return C8;
      default: return 16'h0000;
    endcase
  endfunction

  // exp uses every k, sin the odd ones, cos the even ones.
  function automatic logic k_sel(input logic [1:0] fn, input logic [3:0] k);
    case (fn)
      FN_SIN:  return k[0];
      FN_COS:  return ~k[0];
      default: return 1'b1;
    endcase
  endfunction

  // sin subtracts at k=3,7 and cos at k=2,6: in both cases exactly when k[1] is set.
  function automatic logic k_neg(input logic [1:0] fn, input logic [3:0] k);
    return (fn != FN_EXP) && k[1];
  endfunction

  // Q2.30 -> Q1.15 by >>>15. The only out-of-range product is exactly +1.0
  // ((-1)*(-1)), which is clamped to the largest positive Q1.15 value.
  function automatic logic [15:0] sat_q15(input logic [31:0] prod);
    if (prod[31:30] == 2'b01) return SAT_POS;
    return prod[30:15];
  endfunction

endpackage

// File: rtl/taylor_seq_ctrl_booth.sv
// rtl/taylor_seq_ctrl_booth.sv - 16x16 signed radix-2 Booth multiplier, fixed latency 17
// Purpose: sequential signed multiplier, one Booth step per cycle.
// Ports:   clk, rst (sync, active-high), start (load operands),
//          a/b (signed operands), done (1-cycle pulse 17 cycles after start),
//          p (signed product, valid from done and held until the next start).
module booth_mul16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [31:0] p
);

  // 17-bit partial accumulator so that acc - (-32768) cannot overflow.
  logic [16:0] acc_q, acc_d;
  logic [15:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [15:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [16:0] m_ext;
  logic [16:0] sum;

  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    m_ext  = {m_q[15], m_q};
    sum    = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    if (start) begin
      acc_d = 17'd0;
      q_d   = b;
      qm1_d = 1'b0;
      m_d   = a;
      cnt_d = 5'd16;
    end else if (cnt_q != 5'd0) begin
      // Arithmetic shift of {acc, q, q-1} right by one.
      {acc_d, q_d, qm1_d} = {sum[16], sum, q_q};
      cnt_d  = cnt_q - 5'd1;
      done_d = (cnt_q == 5'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 17'd0;
      q_q    <= 16'd0;
      qm1_q  <= 1'b0;
      m_q    <= 16'd0;
      cnt_q  <= 5'd0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = {acc_q[15:0], q_q};

endmodule

// File: rtl/taylor_seq_ctrl.sv
// rtl/taylor_seq_ctrl.sv - Taylor-series sequencer for exp/sin/cos on one shared Booth multiplier
// Purpose: schedules power and coefficient multiplies, accumulates signed terms,
//          reports one Q17.15 result per accepted request.
// Ports:   clk, rst (sync, active-high), start (request, sampled in IDLE),
//          func (0 exp, 1 sin, 2 cos, 3 illegal), x (Q1.15 argument),
//          busy, done (1-cycle, result valid same cycle), result (Q17.15), err (1-cycle).
module taylor_seq_ctrl
  import taylor_seq_ctrl_pkg::*;
#(
  parameter int unsigned K_MAX = 8,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   func,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [31:0]  result,
  output logic         err
);

  localparam logic [3:0] K_LAST = 4'(K_MAX);

  state_e       state_q, state_d;
  logic [3:0]   k_q, k_d;
  logic [15:0]  x_q, x_d;
  logic [1:0]   fn_q, fn_d;
  logic [15:0]  p_q, p_d;
  logic [31:0]  acc_q, acc_d;
  logic [31:0]  result_q, result_d;
  logic         err_q, err_d;

  logic         mul_start;
  logic [15:0]  mul_a, mul_b;
  logic         mul_done;
  logic [31:0]  mul_p;
  logic [15:0]  prod_q15;
  logic [31:0]  term;

  booth_mul16 u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign prod_q15 = sat_q15(mul_p);
  assign term     = {{16{prod_q15[15]}}, prod_q15};

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    fn_d      = fn_q;
    p_d       = p_q;
    acc_d     = acc_q;
    result_d  = result_q;
    err_d     = 1'b0;
    mul_start = 1'b0;
    mul_a     = p_q;
    mul_b     = x_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (func == FN_ILL) begin
            err_d = 1'b1;
          end else begin
            x_d     = x;
            fn_d    = func;
            p_d     = x;
            k_d     = 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        acc_d   = (fn_q == FN_SIN) ? 32'd0 : {16'd0, ONE_Q15};
        state_d = k_sel(fn_q, k_q) ? S_COEF_START : S_NEXT;
      end
      S_POW_START: begin
        mul_start = 1'b1;
        state_d   = S_POW_WAIT;
      end
      S_POW_WAIT: begin
        if (mul_done) begin
          p_d     = prod_q15;
          state_d = k_sel(fn_q, k_q) ? S_COEF_START : S_NEXT;
        end
      end
      S_COEF_START: begin
        mul_start = 1'b1;
        mul_b     = coef(k_q);
        state_d   = S_COEF_WAIT;
      end
      S_COEF_WAIT: begin
        if (mul_done) state_d = S_ACC;
      end
      S_ACC: begin
        // The multiplier holds its product after done, so the term is read here.
        acc_d   = k_neg(fn_q, k_q) ? (acc_q - term) : (acc_q + term);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (k_q == K_LAST) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_POW_START;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 4'd0;
      x_q      <= 16'd0;
      fn_q     <= FN_EXP;
      p_q      <= 16'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      fn_q     <= fn_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_taylor_seq_ctrl.sv
// tb/tb_taylor_seq_ctrl.sv - directed self-checking bench for taylor_seq_ctrl
module tb_taylor_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic [15:0] x;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  int compared   = 0;
  int mismatched = 0;
  int lat;
  int ndone;

  taylor_seq_ctrl #(.K_MAX(8), .W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .x      (x),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h (%0d) expected 0x%08h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input int center);
    compared++;
    assert (($signed(obs) >= center - 8) && ($signed(obs) <= center + 8)) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d +/- 8", tag, $signed(obs), center);
    end
  endtask

  // Issues one request, scrambles x/func after acceptance, and waits for done.
  // Returns with the bench sitting in the done cycle; lat counts cycles from start.
  task automatic run_op(input logic [1:0] fn, input logic [15:0] xv, output int cyc);
    start = 1'b1;
    func  = fn;
    x     = xv;
    tick();
    start = 1'b0;
    x     = 16'hA5A5;
    func  = 2'd3;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func  = 2'd0;
    x     = 16'h0000;
    tick();
    tick();
    chk("reset_busy",   {31'd0, busy},   32'd0);
    chk("reset_done",   {31'd0, done},   32'd0);
    chk("reset_err",    {31'd0, err},    32'd0);
    chk("reset_result", result,          32'd0);
    rst = 1'b0;
    tick();

    // x = 0: only the accumulator's initial value survives.
    run_op(2'd0, 16'h0000, lat);
    chk("exp0_latency", lat, 32'd288);
    chk("exp0_result",  result, 32'h0000_8000);
    tick();
    run_op(2'd1, 16'h0000, lat);
    chk("sin0_latency", lat, 32'd212);
    chk("sin0_result",  result, 32'h0000_0000);
    tick();
    run_op(2'd2, 16'h0000, lat);
    chk("cos0_latency", lat, 32'd212);
    chk("cos0_result",  result, 32'h0000_8000);
    tick();

    // x = 0.5. Exact sums: 32768+16383+4096+682+85+8 ; 16383-682+8 ; 32768-4096+85.
    run_op(2'd0, 16'h4000, lat);
    chk_tol("exp_half_tol", result, 54025);
    chk("exp_half_exact", result, 32'd54022);
    tick();
    run_op(2'd1, 16'h4000, lat);
    chk_tol("sin_half_tol", result, 15710);
    chk("sin_half_exact", result, 32'd15709);
    tick();
    run_op(2'd2, 16'h4000, lat);
    chk_tol("cos_half_tol", result, 28756);
    chk("cos_half_exact", result, 32'd28757);
    tick();

    // x = -1.0: even powers saturate to 0x7FFF; 32768-16383+1364-45+0.
    run_op(2'd2, 16'h8000, lat);
    chk_tol("cos_m1_tol", result, 17705);
    chk("cos_m1_exact", result, 32'd17704);
    tick();

    // Illegal func: err for one cycle, nothing else moves.
    start = 1'b1;
    func  = 2'd3;
    x     = 16'h1234;
    tick();
    start = 1'b0;
    chk("err_pulse",     {31'd0, err},  32'd1);
    chk("err_busy",      {31'd0, busy}, 32'd0);
    tick();
    chk("err_clear",     {31'd0, err},  32'd0);
    chk("err_busy_late", {31'd0, busy}, 32'd0);
    chk("err_result",    result,        32'd17704);

    // Start while busy and start in the done cycle are both ignored.
    start = 1'b1;
    func  = 2'd0;
    x     = 16'h4000;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 1000) begin
      if (lat == 50) begin
        start = 1'b1;
        func  = 2'd2;
        x     = 16'h0000;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    chk("busy_start_latency", lat, 32'd288);
    chk("busy_start_result",  result, 32'd54022);
    start = 1'b1;
    func  = 2'd1;
    x     = 16'h2000;
    tick();
    start = 1'b0;
    chk("done_start_ignored", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("no_extra_done", ndone, 32'd0);
    chk("result_held",   result, 32'd54022);

    // Reset in the first COEF_WAIT (cycles 3..19 after start) aborts silently.
    start = 1'b1;
    func  = 2'd0;
    x     = 16'h4000;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_done",   {31'd0, done}, 32'd0);
    chk("abort_err",    {31'd0, err},  32'd0);
    chk("abort_result", result,        32'd0);
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    run_op(2'd1, 16'h4000, lat);
    chk("post_abort_latency", lat, 32'd212);
    chk("post_abort_result",  result, 32'd15709);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/taylor_seq_ctrl.md
Name: taylor_seq_ctrl

Overview:
- Sequencer that evaluates exp(x), sin(x) or cos(x) by Taylor series on one shared 16x16 radix-2 Booth multiplier.
- Schedules the power multiplies (x^k = x^(k-1)*x) and the coefficient multiplies (x^k * 1/k!), accumulates signed terms, and reports one result per request.
- Sits beside the per-function Taylor modules as the single scheduled replacement for them.

Parameters:
- K_MAX, 8, highest series index k evaluated; legal range 2..8, bounded by the coefficient table.
- W, 16, operand width; fixed at 16, since the table and formats depend on it.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- func  input  2  0=exp, 1=sin, 2=cos, 3=illegal
- x  input  16  signed Q1.15 argument in [-1, 1)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  32  signed Q17.15 accumulated series; held until the next accepted start
- err  output  1  one-cycle pulse when start arrives in IDLE with func=3

Behaviour:
- Reset: busy=0, done=0, err=0, result=0, FSM=IDLE. The Booth sub-module is re-initialised. A reset mid-operation aborts with no done pulse.
- Coefficient table c[k] = 1/k! in Q1.15, rounded to nearest:
  - c1=0x7FFF (saturated), c2=0x4000, c3=0x1555, c4=0x0555
  - c5=0x0111, c6=0x002E, c7=0x0007, c8=0x0001
- Selected k per function:
  - exp: all k=1..K_MAX, all terms +.
  - sin: odd k; signs +,-,+,- for k=1,3,5,7.
  - cos: even k; signs -,+,-,+ for k=2,4,6,8.
- Accumulator initial value: exp and cos = 0x0000_8000 (1.0); sin = 0.
- Multiply rule: the Q2.30 product is arithmetic-shifted right 15 and truncated to Q1.15.
  - A +1.0 power (e.g. (-1)^2) saturates to 0x7FFF.
  - Terms are sign-extended to 32 bits before the add or subtract.
- FSM:
  - IDLE -> LOAD on start with func!=3. Latch x and func; p=x; k=1.
  - IDLE with start and func=3: pulse err, stay in IDLE.
  - LOAD -> COEF_START if k is selected, else -> NEXT.
  - POW_START: one cycle. Pulse mul_start with a=p, b=x.
  - POW_WAIT: wait for mul_done, then p = sat(product).
    - -> COEF_START if k is selected, else -> NEXT.
  - COEF_START: one cycle. Pulse mul_start with a=p, b=c[k].
  - COEF_WAIT: wait for mul_done -> ACC.
  - ACC: one cycle. acc = acc +/- term -> NEXT.
  - NEXT: one cycle. If k==K_MAX -> DONE; else k=k+1 -> POW_START.
  - DONE: one cycle. result=acc, done=1, busy=0 -> IDLE.
- Multiplier latency: mul_done asserts exactly 17 cycles after the mul_start cycle, so each multiply costs 18 cycles.
- Total latency:
  - exp, K_MAX=8: LOAD + 15 multiplies + 8 ACC + 8 NEXT + DONE = 1 + 270 + 8 + 8 + 1 = 288 cycles from the start cycle to the done cycle.
  - sin and cos: same formula using their own term counts.
- Boundary conditions:
  - start while busy is ignored and does not queue.
  - start in the same cycle as done (FSM in DONE) is ignored.
  - x and func changes after acceptance have no effect.
  - Accumulator overflow is impossible for |x|<1 and K_MAX<=8; no saturation logic on acc.

Decomposition:
- Shared package holds:
  - func encodings FN_EXP, FN_SIN, FN_COS
  - the coefficient table constants c1..c8
  - the Q1.15 constants ONE_Q15=0x8000 and SAT_POS=0x7FFF
  - FSM state typedef
- One sub-module: booth_mul16.
  - Ports: clk, rst, start, a[15:0], b[15:0], done, p[31:0].
  - Signed radix-2 Booth: 16 iterations at one per cycle, fixed latency 17.
  - The controller instantiates it exactly once.

Test Plan:
- x=0x0000 for each func -> exp=0x0000_8000, sin=0x0000_0000, cos=0x0000_8000 exactly; done exactly 288 cycles after start for exp.
- x=0x4000 (0.5), func=exp -> result 54025 +/-8 LSB (about 1.6487).
- x=0x4000, func=sin -> 15710 +/-8; same x, func=cos -> 28756 +/-8.
- x=0x8000 (-1.0), func=cos -> power saturates to 0x7FFF; result 17705 +/-8.
- func=3 with start -> err high for 1 cycle; busy stays 0; result unchanged.
- start pulsed during busy and again during DONE -> ignored with only one done. rst asserted mid-COEF_WAIT -> all outputs 0 next cycle, no done. A new start afterwards completes normally.
